// File: rtl/tiler_pkg.sv
// Shared definitions for the display tiler: writer FSM states, word-count helper
// and the feature-map geometry that both the writer and the tile readers rely on.
package tiler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    localparam int unsigned FMAP_BASE_ADDR = 32'h000;
    localparam int unsigned FMAP_TILE_W    = 24;
    localparam int unsigned FMAP_TILE_H    = 24;
    localparam int unsigned FMAP_WORD_BITS = 256;
    localparam int unsigned FMAP_PIX_BITS  = 8;
    localparam int unsigned FMAP_ADDR_BITS = 12;

    // Number of BRAM words a w x h map occupies when packed ppw pixels per word.
    function automatic int unsigned words_for(input int unsigned w,
                                              input int unsigned h,
                                              input int unsigned ppw);
        return (w * h + ppw - 1) / ppw;
    endfunction

endpackage

// File: rtl/pix_word_packer.sv
// Lane accumulator: drops each accepted pixel into the next lane of a BRAM word
// and presents the word (including the pixel being accepted) combinationally.
module pix_word_packer #(
    parameter int unsigned WORD_BITS = 256,
    parameter int unsigned PIX_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 clr,
    input  logic                 pix_valid,
    input  logic [PIX_BITS-1:0]  pix_in,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_full,
    output logic                 partial
);

    localparam int unsigned PPW = WORD_BITS / PIX_BITS;
    localparam int unsigned LW  = (PPW > 1) ? $clog2(PPW) : 1;

    logic [WORD_BITS-1:0] acc_q, acc_d;
    logic [LW-1:0]        lane_cnt_q, lane_cnt_d;

    // The incoming pixel is merged into its lane so a completing word can be
    // registered by the caller on the same edge that accepts the pixel.
    generate
        for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
            assign word_out[gi*PIX_BITS +: PIX_BITS] =
                (pix_valid && (lane_cnt_q == LW'(gi))) ? pix_in
                                                       : acc_q[gi*PIX_BITS +: PIX_BITS];
        end
    endgenerate

    assign word_full = pix_valid && (lane_cnt_q == LW'(PPW - 1));
    // Pixels are sitting in a word that has not been handed off yet.
    assign partial   = pix_valid ? !word_full : (lane_cnt_q != '0);

    always_comb begin
        acc_d      = acc_q;
        lane_cnt_d = lane_cnt_q;
        if (clr) begin
            acc_d      = '0;
            lane_cnt_d = '0;
        end else if (pix_valid) begin
            if (word_full) begin
                acc_d      = '0;
                lane_cnt_d = '0;
            end else begin
                acc_d      = word_out;
                lane_cnt_d = lane_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_q      <= '0;
            lane_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            lane_cnt_q <= lane_cnt_d;
        end
    end

endmodule

// File: rtl/fmap_bram_writer.sv
// Streams one raster feature map into BRAM port A, PPW pixels per word starting
// at BASE_ADDR, and reports completion and producer length mismatches.
module fmap_bram_writer
    import tiler_pkg::*;
#(
    parameter int unsigned BASE_ADDR = FMAP_BASE_ADDR,
    parameter int unsigned TILE_W    = FMAP_TILE_W,
    parameter int unsigned TILE_H    = FMAP_TILE_H,
    parameter int unsigned WORD_BITS = FMAP_WORD_BITS,
    parameter int unsigned PIX_BITS  = FMAP_PIX_BITS,
    parameter int unsigned ADDR_BITS = FMAP_ADDR_BITS
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_reset,
    input  logic                 start,
    input  logic [PIX_BITS-1:0]  s_pixel,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 bram_we,
    output logic [ADDR_BITS-1:0] bram_addr,
    output logic [WORD_BITS-1:0] bram_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len
);

    localparam int unsigned PPW    = WORD_BITS / PIX_BITS;
    localparam int unsigned NPIX   = TILE_W * TILE_H;
    localparam int unsigned NWORDS = words_for(TILE_W, TILE_H, PPW);
    localparam int unsigned PCW    = $clog2(NPIX + 1);
    localparam int unsigned WCW    = $clog2(NWORDS + 1);

    generate
        if ((WORD_BITS % PIX_BITS) != 0) begin : g_bad_pix_bits
            $error("fmap_bram_writer: WORD_BITS must be a multiple of PIX_BITS");
        end
        if ((longint'(BASE_ADDR) + longint'(NWORDS)) > (longint'(1) << ADDR_BITS)) begin : g_bad_addr_range
            $error("fmap_bram_writer: map does not fit in the BRAM address space");
        end
    endgenerate

    wr_state_t            state_q, state_d;
    logic [PCW-1:0]       pix_cnt_q, pix_cnt_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d;
    logic                 err_len_q, err_len_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_BITS-1:0] wdata_q, wdata_d;

    logic                 accept;
    logic                 pk_clr;
    logic [WORD_BITS-1:0] pk_word;
    logic                 pk_full;
    logic                 pk_partial;
    logic                 last_pix;
    logic                 end_map;

    assign accept   = (state_q == FILL) && s_valid;
    assign last_pix = (pix_cnt_q == PCW'(NPIX - 1));
    assign end_map  = accept && (last_pix || s_last);

    pix_word_packer #(
        .WORD_BITS (WORD_BITS),
        .PIX_BITS  (PIX_BITS)
    ) u_packer (
        .clk       (out_stream_aclk),
        .srst      (periph_reset),
        .clr       (pk_clr),
        .pix_valid (accept),
        .pix_in    (s_pixel),
        .word_out  (pk_word),
        .word_full (pk_full),
        .partial   (pk_partial)
    );

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        word_cnt_d = word_cnt_q;
        err_len_d  = err_len_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pk_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    pix_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_len_d  = 1'b0;
                    pk_clr     = 1'b1;
                end
            end
            FILL: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + PCW'(1);
                    // The trailing partial word is registered on the same edge as the
                    // final pixel, so its write lands in FLUSH like a full word would.
                    if (pk_full || (end_map && pk_partial)) begin
                        we_d       = 1'b1;
                        addr_d     = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(word_cnt_q);
                        wdata_d    = pk_word;
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                    if (end_map) begin
                        state_d = FLUSH;
                        if (last_pix != s_last) begin
                            err_len_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_len_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_len_q  <= err_len_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign s_ready    = (state_q == FILL);
    assign busy       = (state_q == FILL) || (state_q == FLUSH);
    assign done       = (state_q == DONE);
    assign err_len    = err_len_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

endmodule

// File: tb/tb_fmap_bram_writer.sv
// Scoreboard bench: a 24x24 map at base 0 and a 10x10 map at base 0x020; the
// drivers queue expected BRAM writes and done/err_len, a negedge monitor checks them.
module tb_fmap_bram_writer;

    localparam int WB = 256;
    localparam int AB = 12;

    typedef struct {
        logic [AB-1:0] addr;
        logic [WB-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                periph_reset;
    logic [1:0]          start_s, valid_s, last_s;
    logic [1:0][7:0]     pix_s;
    logic [1:0]          ready_w, we_w, busy_w, done_w, err_w;
    logic [1:0][AB-1:0]  addr_w;
    logic [1:0][WB-1:0]  wdata_w;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t exp_wr[2][$];
    bit  exp_err[2][$];
    bit  prev_we[2] = '{1'b0, 1'b0};
    int  base_of[2] = '{0, 32};
    int  npix_of[2] = '{576, 100};

    fmap_bram_writer #(
        .BASE_ADDR (32'h000), .TILE_W (24), .TILE_H (24),
        .WORD_BITS (256), .PIX_BITS (8), .ADDR_BITS (12)
    ) dut_a (
        .out_stream_aclk (clk),        .periph_reset (periph_reset),
        .start           (start_s[0]), .s_pixel      (pix_s[0]),
        .s_valid         (valid_s[0]), .s_last       (last_s[0]),
        .s_ready         (ready_w[0]), .bram_we      (we_w[0]),
        .bram_addr       (addr_w[0]),  .bram_wdata   (wdata_w[0]),
        .busy            (busy_w[0]),  .done         (done_w[0]),
        .err_len         (err_w[0])
    );

    fmap_bram_writer #(
        .BASE_ADDR (32'h020), .TILE_W (10), .TILE_H (10),
        .WORD_BITS (256), .PIX_BITS (8), .ADDR_BITS (12)
    ) dut_b (
        .out_stream_aclk (clk),        .periph_reset (periph_reset),
        .start           (start_s[1]), .s_pixel      (pix_s[1]),
        .s_valid         (valid_s[1]), .s_last       (last_s[1]),
        .s_ready         (ready_w[1]), .bram_we      (we_w[1]),
        .bram_addr       (addr_w[1]),  .bram_wdata   (wdata_w[1]),
        .busy            (busy_w[1]),  .done         (done_w[1]),
        .err_len         (err_w[1])
    );

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Word k of a map whose first m pixels (value = index mod 256) were sent.
    function automatic logic [WB-1:0] exp_word(input int k, input int m);
        logic [WB-1:0] w;
        int idx;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            idx = 32 * k + j;
            if (idx < m) w[j*8 +: 8] = idx[7:0];
        end
        return w;
    endfunction

    always @(negedge clk) begin
        wr_t e;
        bit  ee;
        for (int d = 0; d < 2; d++) begin
            if (we_w[d] === 1'b1) begin
                if (exp_wr[d].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write dut%0d: got write at addr %h, required no write", d, addr_w[d]);
                end else begin
                    e = exp_wr[d].pop_front();
                    $display("dut%0d write addr=%h data=%h", d, addr_w[d], wdata_w[d]);
                    check($sformatf("wr_addr dut%0d", d), WB'(addr_w[d]), WB'(e.addr));
                    check($sformatf("wr_data dut%0d addr %h", d, e.addr), wdata_w[d], e.data);
                end
            end
            if (done_w[d] === 1'b1) begin
                if (exp_err[d].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done dut%0d: got done=1, required 0", d);
                end else begin
                    ee = exp_err[d].pop_front();
                    $display("dut%0d done err_len=%0d", d, err_w[d]);
                    check($sformatf("done_after_write dut%0d", d), WB'(prev_we[d]), WB'(1));
                    check($sformatf("err_len dut%0d", d), WB'(err_w[d]), WB'(ee));
                end
            end
            prev_we[d] = (we_w[d] === 1'b1);
        end
    end

    // Sends pixels 0..n-1 to DUT d; s_last on index last_idx (-1: never). start_at
    // re-pulses start mid-map; abort leaves the map unfinished for a reset.
    task automatic run_map(input int d, input int n, input int last_idx, input int gap_pct,
                           input int start_at, input bit abort);
        int i;
        int cyc;
        bit acc;
        wr_t e;
        int nw;
        i   = 0;
        cyc = 0;
        nw  = abort ? (n / 32) : ((n + 31) / 32);
        for (int k = 0; k < nw; k++) begin
            e.addr = AB'(base_of[d] + k);
            e.data = exp_word(k, n);
            exp_wr[d].push_back(e);
        end
        if (!abort) exp_err[d].push_back(!(n == npix_of[d] && last_idx == npix_of[d] - 1));

        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        while (i < n && cyc < 20000) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                valid_s[d] = 1'b0;
                last_s[d]  = 1'b0;
            end else begin
                valid_s[d] = 1'b1;
                pix_s[d]   = i[7:0];
                last_s[d]  = (i == last_idx);
            end
            if (i == start_at) start_s[d] = 1'b1;
            acc = valid_s[d] && ready_w[d];
            @(posedge clk); #1;
            start_s[d] = 1'b0;
            if (acc) i++;
            cyc++;
        end
        last_s[d] = 1'b0;
        valid_s[d] = (last_idx < 0) && !abort;
        pix_s[d] = 8'hEE;
        if (i < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stim_timeout dut%0d: got %0d pixels accepted, required %0d", d, i, n);
        end
        if (!abort) begin
            if (last_idx < 0) check($sformatf("ready_after_npix dut%0d", d), WB'(ready_w[d]), WB'(0));
            for (int t = 0; t < 40 && busy_w[d]; t++) begin
                @(posedge clk); #1;
            end
            check($sformatf("busy_clear dut%0d", d), WB'(busy_w[d]), WB'(0));
            repeat (3) begin
                @(posedge clk); #1;
            end
            valid_s[d] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        periph_reset = 1'b1;
        start_s = '0;
        valid_s = '0;
        last_s  = '0;
        pix_s   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_s_ready dut%0d", d), WB'(ready_w[d]), WB'(0));
            check($sformatf("rst_bram_we dut%0d", d), WB'(we_w[d]), WB'(0));
            check($sformatf("rst_bram_addr dut%0d", d), WB'(addr_w[d]), WB'(0));
            check($sformatf("rst_bram_wdata dut%0d", d), wdata_w[d], WB'(0));
            check($sformatf("rst_busy dut%0d", d), WB'(busy_w[d]), WB'(0));
            check($sformatf("rst_done dut%0d", d), WB'(done_w[d]), WB'(0));
            check($sformatf("rst_err_len dut%0d", d), WB'(err_w[d]), WB'(0));
        end
        @(posedge clk); #1;
        periph_reset = 1'b0;
        @(posedge clk); #1;

        run_map(0, 576, 575, 0, -1, 1'b0);   // full 24x24 map, back-to-back pixels
        run_map(1, 100, 99, 0, -1, 1'b0);    // 10x10 map at 0x020, trailing partial word
        run_map(0, 576, 575, 50, -1, 1'b0);  // same map with random valid gaps
        run_map(0, 41, 40, 0, -1, 1'b0);     // early s_last on pixel 40

        run_map(0, 51, -1, 0, -1, 1'b1);     // abandoned by reset after pixel 50
        periph_reset = 1'b1;
        @(posedge clk); #1;
        check("abort_s_ready dut0", WB'(ready_w[0]), WB'(0));
        check("abort_busy dut0", WB'(busy_w[0]), WB'(0));
        @(posedge clk); #1;
        periph_reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        run_map(0, 576, 575, 0, -1, 1'b0);   // clean map after the abort

        run_map(0, 576, 575, 0, 100, 1'b0);  // start re-pulsed mid-map
        run_map(1, 100, -1, 0, -1, 1'b0);    // NPIX reached with no s_last

        repeat (5) begin
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("writes_outstanding dut%0d", d), WB'(exp_wr[d].size()), WB'(0));
            check($sformatf("dones_outstanding dut%0d", d), WB'(exp_err[d].size()), WB'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
